// File: rtl/x_mem_arb2.sv
// Two-master arbiter for the single valid/accept memory port; zero-latency forwarding, grant locked until accept.
// Round-robin on contention by default; define X_MEM_ARB2_FIXED_PRIO_EN to give master 0 fixed priority.
module x_mem_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_m0_valid,
    input  logic          i_m0_rnw,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic          o_m0_accept,
    output logic [DW-1:0] o_m0_data,
    input  logic          i_m1_valid,
    input  logic          i_m1_rnw,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic          o_m1_accept,
    output logic [DW-1:0] o_m1_data,
    output logic          o_valid,
    output logic          o_rnw,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    input  logic [DW-1:0] i_data,
    input  logic          i_accept
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       req_vld;
    logic       req_sel;
    logic       fwd;

    // Which master (if any) is presented downstream this cycle.
    always_comb begin
        req_vld = 1'b0;
        req_sel = 1'b0;
        case (state_q)
            IDLE: begin
                req_vld = i_m0_valid | i_m1_valid;
                if (i_m0_valid && i_m1_valid) begin
`ifdef X_MEM_ARB2_FIXED_PRIO_EN
                    req_sel = 1'b0;
`else
                    req_sel = ~last_q;
`endif
                end else begin
                    req_sel = i_m1_valid;
                end
            end
            OWN0: begin
                req_vld = i_m0_valid;
                req_sel = 1'b0;
            end
            OWN1: begin
                req_vld = i_m1_valid;
                req_sel = 1'b1;
            end
            default: begin
                req_vld = 1'b0;
                req_sel = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (i_accept) begin
`ifndef X_MEM_ARB2_FIXED_PRIO_EN
                        last_d = req_sel;
`endif
                    end else begin
                        state_d = req_sel ? OWN1 : OWN0;
                    end
                end
            end
            OWN0, OWN1: begin
                // A withdrawn request releases the lock without counting as served.
                if (!req_vld) begin
                    state_d = IDLE;
                end else if (i_accept) begin
                    state_d = IDLE;
`ifndef X_MEM_ARB2_FIXED_PRIO_EN
                    last_d  = req_sel;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Reset gates the outputs so the downstream sees the request vanish at once.
    assign fwd = req_vld & i_nrst;

    assign o_valid     = fwd;
    assign o_rnw       = fwd & (req_sel ? i_m1_rnw : i_m0_rnw);
    assign o_addr      = fwd ? (req_sel ? i_m1_addr : i_m0_addr) : '0;
    assign o_data      = fwd ? (req_sel ? i_m1_data : i_m0_data) : '0;
    assign o_m0_accept = fwd & i_accept & ~req_sel;
    assign o_m1_accept = fwd & i_accept & req_sel;
    assign o_m0_data   = i_data;
    assign o_m1_data   = i_data;

endmodule
